// File: rtl/imem_pkg.sv
// Shared FSM state, constants and parameter defaults for the instruction prefetcher.
package imem_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [DEF_DATA_W-1:0] NOP = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is visible combinationally, push-to-head 1 edge.
// No internal overflow guard: the producer must throttle on count_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Depth is a power of two, so pointers wrap by overflow.
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/imem_prefetch.sv
// Instruction memory with sequential prefetch into a small buffer; issue-to-head 2 edges.
// Issue stops while level + in-flight would exceed the buffer; consumer stalls with out_ready.
module imem_prefetch
  import imem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            prog_we,
  input  logic [ADDR_W-1:0]               prog_addr,
  input  logic [DATA_W-1:0]               prog_data,
  input  logic                            fetch_en,
  input  logic                            redirect,
  input  logic [ADDR_W-1:0]               redirect_addr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_instr,
  output logic [ADDR_W-1:0]               out_pc,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              epoch_q, epoch_d;

  logic              rd_vld_q;
  logic              rd_epoch_q;
  logic [ADDR_W-1:0] rd_pc_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              issue;
  logic              push;
  logic              pop;
  logic              in_flight;
  logic [LVL_W-1:0]  occ;
  logic [DATA_W-1:0] head_instr;
  logic [ADDR_W-1:0] head_pc;

  assign in_flight = rd_vld_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    issue      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    occ        = level + LVL_W'(in_flight);

    case (state_q)
      ST_IDLE: if (fetch_en)  state_d = ST_RUN;
      ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Redirect wins over everything: no issue, no push, no pop that cycle.
    if (redirect) begin
      fetch_pc_d = redirect_addr;
      epoch_d    = ~epoch_q;
    end else begin
      issue = (state_q == ST_RUN) && (occ < LVL_W'(FIFO_DEPTH));
      push  = rd_vld_q && (rd_epoch_q == epoch_q);
      pop   = out_valid && out_ready;
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
      epoch_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_epoch_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
      rd_vld_q   <= issue;
      if (issue) begin
        rd_epoch_q <= epoch_q;
        rd_pc_q    <= fetch_pc_q;
        rd_data_q  <= mem_q[fetch_pc_q];
      end
    end
  end

  // Kept apart from the reset block so reset never touches the program image.
  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end

  sync_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (redirect),
    .push_i     (push),
    .push_dat_i ({rd_pc_q, rd_data_q}),
    .pop_i      (pop),
    .head_dat_o ({head_pc, head_instr}),
    .count_o    (level)
  );

  assign out_valid = (level != '0);
  assign out_instr = out_valid ? head_instr : DATA_W'(NOP);
  assign out_pc    = out_valid ? head_pc    : '0;

endmodule

// File: tb/tb_imem_prefetch.sv
// Directed and randomized checks of imem_prefetch against a sequential-stream memory model.
module tb_imem_prefetch;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              fetch_en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [LVL_W-1:0]  level;

  logic [DATA_W-1:0] mem_model [2**ADDR_W];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_prefetch #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .fetch_en      (fetch_en),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .level         (level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_edges, output int n);
    n = 0;
    while (!out_valid && n < max_edges) begin
      tick();
      n++;
    end
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    tick();
    redirect      = 1'b0;
  endtask

  // Expects the head to be the word at pc, then pops it (out_ready must be 1).
  task automatic pop_expect(input string tag, input logic [ADDR_W-1:0] pc);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_pc"},    out_pc,    pc);
    check({tag, "_instr"}, out_instr, mem_model[pc]);
    tick();
  endtask

  initial begin
    int                n;
    logic [ADDR_W-1:0] exp_pc;
    logic [DATA_W-1:0] old5;
    logic [DATA_W-1:0] new5;
    logic              r_ready, r_redir, stall_prev;
    logic [ADDR_W-1:0] hold_pc;
    logic [DATA_W-1:0] hold_instr;

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    fetch_en = 1'b0; redirect = 1'b0; redirect_addr = '0; out_ready = 1'b0;

    // Program image loaded while reset is held.
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem_model[i] = (i < 8) ? (32'h1000_0000 + i) : $urandom;
      prog_we   = 1'b1;
      prog_addr = ADDR_W'(i);
      prog_data = mem_model[i];
      tick();
    end
    prog_we = 1'b0;
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc",    out_pc, 0);
    rst_n = 1'b1;

    // Sequential stream from 0 with the consumer always ready.
    out_ready = 1'b1;
    fetch_en  = 1'b1;
    wait_valid(10, n);
    check("seq_first_valid", out_valid, 1);
    for (int k = 0; k < 8; k++) pop_expect("seq", ADDR_W'(k));

    // Stop issue and drain; then a redirect while idle must not issue.
    fetch_en = 1'b0;
    repeat (6) tick();
    check("drain_empty", out_valid, 0);
    do_redirect('0);
    repeat (3) tick();
    check("idle_redir_valid", out_valid, 0);
    check("idle_redir_level", level, 0);

    // Stalled consumer: buffer saturates with pc 0 at the head.
    out_ready = 1'b0;
    fetch_en  = 1'b1;
    repeat (12) tick();
    check("sat_level", level, DEPTH);
    check("sat_valid", out_valid, 1);
    check("sat_pc",    out_pc, 0);
    check("sat_instr", out_instr, mem_model[0]);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) pop_expect("release", ADDR_W'(k));

    // Redirect with three entries buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 10 && level != 3; i++) tick();
    check("pre_redir_level3", level, 3);
    do_redirect(8'h0E);
    check("redir_valid0", out_valid, 0);
    check("redir_level0", level, 0);
    out_ready = 1'b1;
    wait_valid(6, n);
    check("redir_lat_le3", (n <= 3), 1);
    for (int k = 0; k < 3; k++) pop_expect("redir", ADDR_W'(8'h0E + k));

    // Address wrap.
    do_redirect(8'hFE);
    wait_valid(6, n);
    for (int k = 0; k < 4; k++) pop_expect("wrap", ADDR_W'(8'hFE + k));

    // Write colliding with the read issue of address 5 returns the old word.
    do_redirect(8'h05);
    old5 = mem_model[5];
    new5 = 32'hCAFE_0005;
    prog_we = 1'b1; prog_addr = 8'h05; prog_data = new5;
    tick();
    prog_we = 1'b0;
    wait_valid(6, n);
    check("rfirst_pc",    out_pc, 8'h05);
    check("rfirst_instr", out_instr, old5);
    mem_model[5] = new5;
    do_redirect(8'h05);
    wait_valid(6, n);
    pop_expect("refetch", 8'h05);

    // Random consumer backpressure, redirects and fetch enable toggles.
    do_redirect(8'h20);
    exp_pc     = 8'h20;
    stall_prev = 1'b0;
    hold_pc    = '0;
    hold_instr = '0;
    for (int c = 0; c < 500; c++) begin
      r_ready = ($urandom_range(0, 9) < 6);
      r_redir = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) fetch_en = ~fetch_en;
      if (stall_prev) begin
        check("rnd_hold_valid", out_valid, 1);
        check("rnd_hold_pc",    out_pc, hold_pc);
        check("rnd_hold_instr", out_instr, hold_instr);
      end
      check("rnd_level_max", (level <= DEPTH), 1);
      out_ready     = r_ready;
      redirect      = r_redir;
      redirect_addr = ADDR_W'($urandom);
      stall_prev    = out_valid && !r_ready && !r_redir;
      hold_pc       = out_pc;
      hold_instr    = out_instr;
      if (r_redir) begin
        exp_pc = redirect_addr;
      end else if (out_valid && r_ready) begin
        check("rnd_pc",    out_pc, exp_pc);
        check("rnd_instr", out_instr, mem_model[exp_pc]);
        exp_pc = exp_pc + ADDR_W'(1);
      end
      tick();
      if (r_redir) check("rnd_redir_valid0", out_valid, 0);
      redirect = 1'b0;
    end

    // Reset with a full buffer drops everything; fetch restarts at 0.
    out_ready = 1'b0;
    fetch_en  = 1'b1;
    for (int i = 0; i < 12 && level != DEPTH; i++) tick();
    check("prerst_full", level, DEPTH);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_level", level, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_pc",    out_pc, 0);
    check("midrst_instr", out_instr, 0);
    out_ready = 1'b1;
    tick();
    check("postrst_no_spurious", out_valid, 0);
    wait_valid(6, n);
    pop_expect("restart", 8'h00);
    pop_expect("restart", 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
